// File: rtl/cpu_trace_emitter_if.sv
// Record handshake between a CPU write-back source and cpu_trace_emitter.
//   in_valid/in_ready : one record is transferred when both are high at a rising edge
//   in_kind           : 0 = register write, 1 = memory write
//   in_time           : 4 BCD nibbles, MS digit first
//   in_pc             : program counter (8 hex digits)
//   in_grf            : register number, 2 BCD nibbles (register records only)
//   in_addr           : memory address (memory records only)
//   in_data           : write data
interface cpu_trace_emitter_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_kind;
   logic [15:0] in_time;
   logic [31:0] in_pc;
   logic [7:0]  in_grf;
   logic [31:0] in_addr;
   logic [31:0] in_data;

   modport master (
      output in_valid, in_kind, in_time, in_pc, in_grf, in_addr, in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_kind, in_time, in_pc, in_grf, in_addr, in_data,
      output in_ready
   );
endinterface

// File: rtl/cpu_trace_emitter.sv
// Serialises one write-back record per handshake into the ASCII trace stream,
// one character per clock:
//   register write : ^T@PPPPPPPP: $G <= DDDDDDDD#
//   memory write   : ^T@PPPPPPPP: *AAAAAAAA <= DDDDDDDD#
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   in_if      : record handshake (slave side), in_ready registered
//   char_o     : registered ASCII character, 8'h00 when idle
//   busy_o     : registered, high while a record is being emitted
module cpu_trace_emitter (
   input  logic                  clk,
   input  logic                  reset,
   cpu_trace_emitter_if.slave    in_if,
   output logic [7:0]            char_o,
   output logic                  busy_o
);

   localparam int unsigned CW = 3;

   localparam logic [7:0] CH_NUL   = 8'h00;
   localparam logic [7:0] CH_HAT   = 8'h5e;
   localparam logic [7:0] CH_AT    = 8'h40;
   localparam logic [7:0] CH_COLON = 8'h3a;
   localparam logic [7:0] CH_SP    = 8'h20;
   localparam logic [7:0] CH_DOLR  = 8'h24;
   localparam logic [7:0] CH_STAR  = 8'h2a;
   localparam logic [7:0] CH_LT    = 8'h3c;
   localparam logic [7:0] CH_EQ    = 8'h3d;
   localparam logic [7:0] CH_HASH  = 8'h23;

   typedef enum logic [3:0] {
      S_IDLE, S_HAT, S_TIME, S_AT, S_PC, S_COLON, S_SP0, S_KIND,
      S_OPND, S_SP1, S_LT, S_EQ, S_SP2, S_DATA, S_HASH
   } state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [7:0]      char_q;
   logic            busy_q;
   logic            ready_q;
   logic            kind_q;
   logic [15:0]     time_q;
   logic [31:0]     pc_q;
   logic [7:0]      grf_q;
   logic [31:0]     addr_q;
   logic [31:0]     data_q;

   logic            accept;
   logic [1:0]      time_start;
   logic [CW-1:0]   grf_start;
   logic [CW-1:0]   cnt_inc;
   logic            opnd_last;

   // Nibble value to ASCII; BCD nibbles above 9 deliberately come out as letters.
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      else           return 8'h57 + {4'h0, n};
   endfunction

   // Nibble i of a 32-bit field, i = 0 is the most significant.
   function automatic logic [3:0] nib32(input logic [31:0] v, input logic [CW-1:0] i);
      return 4'(v >> {3'd7 - i, 2'b00});
   endfunction

   function automatic logic [3:0] nib16(input logic [15:0] v, input logic [1:0] i);
      return 4'(v >> {2'd3 - i, 2'b00});
   endfunction

   function automatic logic [3:0] nib8(input logic [7:0] v, input logic i);
      return i ? v[3:0] : v[7:4];
   endfunction

   // Start indices for leading-zero suppression; an all-zero field keeps its last digit.
   always_comb begin
      accept     = in_if.in_valid && ready_q;
      cnt_inc    = CW'(cnt_q + CW'(1));
      opnd_last  = kind_q ? (cnt_q == CW'(7)) : (cnt_q == CW'(1));
      grf_start  = (grf_q[7:4] == 4'h0) ? CW'(1) : CW'(0);
      time_start = 2'd3;
      if (time_q[15:12] != 4'h0)     time_start = 2'd0;
      else if (time_q[11:8] != 4'h0) time_start = 2'd1;
      else if (time_q[7:4] != 4'h0)  time_start = 2'd2;
   end

   // Sequencer: char_q always carries the character of the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         char_q  <= CH_NUL;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
         kind_q  <= 1'b0;
         time_q  <= '0;
         pc_q    <= '0;
         grf_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_HASH: begin
               cnt_q <= '0;
               if (accept) begin
                  kind_q  <= in_if.in_kind;
                  time_q  <= in_if.in_time;
                  pc_q    <= in_if.in_pc;
                  grf_q   <= in_if.in_grf;
                  addr_q  <= in_if.in_addr;
                  data_q  <= in_if.in_data;
                  state_q <= S_HAT;
                  char_q  <= CH_HAT;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
               end else begin
                  state_q <= S_IDLE;
                  char_q  <= CH_NUL;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            S_HAT: begin
               state_q <= S_TIME;
               cnt_q   <= {1'b0, time_start};
               char_q  <= hex_ascii(nib16(time_q, time_start));
            end
            S_TIME: begin
               if (cnt_q[1:0] == 2'd3) begin
                  state_q <= S_AT;
                  cnt_q   <= '0;
                  char_q  <= CH_AT;
               end else begin
                  cnt_q  <= cnt_inc;
                  char_q <= hex_ascii(nib16(time_q, cnt_inc[1:0]));
               end
            end
            S_AT: begin
               state_q <= S_PC;
               cnt_q   <= '0;
               char_q  <= hex_ascii(nib32(pc_q, CW'(0)));
            end
            S_PC: begin
               if (cnt_q == CW'(7)) begin
                  state_q <= S_COLON;
                  cnt_q   <= '0;
                  char_q  <= CH_COLON;
               end else begin
                  cnt_q  <= cnt_inc;
                  char_q <= hex_ascii(nib32(pc_q, cnt_inc));
               end
            end
            S_COLON: begin
               state_q <= S_SP0;
               char_q  <= CH_SP;
            end
            S_SP0: begin
               state_q <= S_KIND;
               char_q  <= kind_q ? CH_STAR : CH_DOLR;
            end
            S_KIND: begin
               state_q <= S_OPND;
               if (kind_q) begin
                  cnt_q  <= '0;
                  char_q <= hex_ascii(nib32(addr_q, CW'(0)));
               end else begin
                  cnt_q  <= grf_start;
                  char_q <= hex_ascii(nib8(grf_q, grf_start[0]));
               end
            end
            S_OPND: begin
               if (opnd_last) begin
                  state_q <= S_SP1;
                  cnt_q   <= '0;
                  char_q  <= CH_SP;
               end else begin
                  cnt_q  <= cnt_inc;
                  char_q <= kind_q ? hex_ascii(nib32(addr_q, cnt_inc))
                                   : hex_ascii(nib8(grf_q, cnt_inc[0]));
               end
            end
            S_SP1: begin
               state_q <= S_LT;
               char_q  <= CH_LT;
            end
            S_LT: begin
               state_q <= S_EQ;
               char_q  <= CH_EQ;
            end
            S_EQ: begin
               state_q <= S_SP2;
               char_q  <= CH_SP;
            end
            S_SP2: begin
               state_q <= S_DATA;
               cnt_q   <= '0;
               char_q  <= hex_ascii(nib32(data_q, CW'(0)));
            end
            S_DATA: begin
               if (cnt_q == CW'(7)) begin
                  state_q <= S_HASH;
                  cnt_q   <= '0;
                  char_q  <= CH_HASH;
                  ready_q <= 1'b1;
               end else begin
                  cnt_q  <= cnt_inc;
                  char_q <= hex_ascii(nib32(data_q, cnt_inc));
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               char_q  <= CH_NUL;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_if.in_ready = ready_q;
   assign char_o         = char_q;
   assign busy_o         = busy_q;

endmodule

// File: doc/cpu_trace_emitter.md
# cpu_trace_emitter

Serialises one CPU write-back record per handshake into the ASCII character stream that the downstream trace checker consumes, one character per clock. It sits directly upstream of the checker: its `char` output drives the checker's `char` input. Register-write records have the form `^T@PPPPPPPP: $G <= DDDDDDDD#`; memory-write records have the form `^T@PPPPPPPP: *AAAAAAAA <= DDDDDDDD#`. The block can also inject malformed digits so the checker's error path can be exercised.

## Interface
No parameters.

- `clk` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: a record is presented on the input fields.
- `in_ready` output 1: the block can accept a record this cycle.
- `in_kind` input 1: record type. 0 = register write (`$`), 1 = memory write (`*`).
- `in_time` input 16: timestamp as 4 BCD nibbles, most-significant digit first.
- `in_pc` input 32: PC, emitted as 8 hex digits.
- `in_grf` input 8: register number as 2 BCD nibbles. Used only when `in_kind`=0.
- `in_addr` input 32: memory address, 8 hex digits. Used only when `in_kind`=1.
- `in_data` input 32: write data, 8 hex digits.
- `char` output 8: current ASCII character. 8'h00 when idle.
- `busy` output 1: a record is being emitted.

## Operation
**Handshake**
- A record is accepted on a rising edge where `in_valid && in_ready`.
- All input fields are latched at that edge. Inputs are don't-care afterwards.
- `in_ready` = 1 in IDLE, and also during the cycle in which `#` is on `char`. This allows back-to-back records with no gap.

**State sequence.** Each state below occupies one cycle per character:
- `HAT` emits `^`.
- `TIME` emits the time digits.
- `AT` emits `@`.
- `PC` emits 8 characters.
- `COLON` emits `:`.
- `SP0` emits a space.
- `KIND` emits `$` or `*`.
- `OPND` emits either the grf digits or 8 address characters.
- `SP1` emits a space.
- `LT` emits `<`.
- `EQ` emits `=`.
- `SP2` emits a space.
- `DATA` emits 8 characters.
- `HASH` emits `#`.
- After `HASH`: go to `HAT` if a new record was accepted, otherwise go to IDLE.

**Digit counter.** A 3-bit counter indexes nibbles within `TIME`, `PC`, `OPND` and `DATA`, most-significant nibble first.

**Nibble-to-ASCII mapping**
- 0–9 map to `0`–`9`.
- 10–15 map to lowercase `a`–`f`.
- The same mapping applies to BCD fields. A BCD nibble greater than 9 is emitted as a letter; this is the deliberate error-injection path. Nibbles are never corrected.

**Leading-zero suppression**
- Applies to `TIME` and to grf only.
- Emission starts at the first nonzero nibble.
- An all-zero field emits a single `0`.
- Time is therefore 1–4 characters and grf is 1–2 characters.
- PC, address and data always emit all 8 digits, including leading zeros.

**Record length**
- Register record: 26 + time digits + grf digits. Range 28–32 characters.
- Memory record: 34 + time digits. Range 35–38 characters.

**Other outputs**
- `busy` = 1 in every non-IDLE state.
- In IDLE, `char` = 8'h00.

## Timing
- **Reset values:** `char`=8'h00, `busy`=0, `in_ready`=1. State is IDLE, counter is 0, latched fields are cleared.
- **Latency:** if a record is accepted at edge k, `^` appears on `char` in the cycle after edge k. Each following edge advances exactly one character; there are no stalls.
- **`char` is registered.** It changes only on rising edges.
- **Back-to-back:** if a record is accepted at the edge that ends the `#` cycle, `^` appears in the next cycle with no 8'h00 gap.
- **Reset mid-record:** at the next edge, `char`=8'h00 and the state returns to IDLE. The partial record is dropped, with no `#`. A record offered in the same cycle as reset is not accepted.
- **`in_valid` while busy:** ignored, except during the `#` cycle.
- **Field latching:** fields are sampled only at the accept edge. Changing the inputs mid-record does not affect the output.

## Test plan
1. **Register record.** Reset, then accept time=16'h1023, pc=32'h000020fc, kind=0, grf=8'h05, data=32'h89abcdef. Required: `char` sequence is `^1023@000020fc: $5 <= 89abcdef#` (31 characters, starting the cycle after accept), then 8'h00. `busy` is high for exactly 31 cycles.
2. **Memory record with zero suppression.** time=16'h0006, pc=0, kind=1, addr=32'h00001000, data=0. Required: `^6@00000000: *00001000 <= 00000000#` (35 characters).
3. **All-zero BCD fields.** time=16'h0000, grf=8'h00. Required: time emits `0` and grf emits `0` (single characters); total length is 28.
4. **Back-to-back.** Hold `in_valid`=1 with two records. Required: the second `^` immediately follows the first `#`. `in_ready` is high only during IDLE and the `#` cycles.
5. **Error injection.** time=16'h1a03. Required: the time field emits `1a03` unchanged.
6. **Reset mid-record.** Assert reset during the `PC` state. Required: `char`=8'h00, `busy`=0 and `in_ready`=1 on the next cycle. A new record accepted afterwards emits correctly from `^`.
